spartan_sync_gasket: RTL

- Single-clock, parametrised Spartan bus gasket between an A side (upstream master) and a B side (downstream slave).
- Provides independent, depth-configurable buffering for the master direction (A→B) and the slave/response direction (B→A).
- Provides occupancy reporting for both FIFOs and an optional outstanding-beat limiter that throttles new master traffic.
- Used wherever bus segments on the same clock need decoupling, retiming or back-pressure control.

---
 rtl/spartan_sync_gasket.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spartan_sync_gasket.sv
// Spartan bus gasket: independent master/slave FIFOs with occupancy
// reporting and an optional outstanding-beat limiter on the A master side.

module spartan_sync_gasket_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEP = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Guarding here keeps the level from ever leaving 0..DEPTH.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  assign full  = (level == DEP);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)
        level <= level + LW'(1);
      else if (rd_en && !wr_en)
        level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

endmodule

module spartan_sync_gasket #(
  parameter int BWIDTH  = 64,
  parameter int MDEPTH  = 4,
  parameter int SDEPTH  = 4,
  parameter int MAX_OUT = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [BWIDTH+1:0]              SpMBUS_A,
  input  logic                           SpMVLD_A,
  output logic                           SpMRDY_A,
  output logic [BWIDTH+1:0]              SpSBUS_A,
  output logic                           SpSVLD_A,
  input  logic                           SpSRDY_A,
  output logic [BWIDTH+1:0]              SpMBUS_B,
  output logic                           SpMVLD_B,
  input  logic                           SpMRDY_B,
  input  logic [BWIDTH+1:0]              SpSBUS_B,
  input  logic                           SpSVLD_B,
  output logic                           SpSRDY_B,
  output logic [$clog2(MDEPTH):0]        MLEVEL,
  output logic [$clog2(SDEPTH):0]        SLEVEL,
  output logic [$clog2(MAX_OUT+1):0]     OUTSTND
);

  localparam int W  = BWIDTH + 2;
  localparam int OW = $clog2(MAX_OUT + 1) + 1;

  logic en;
  logic m_full;
  logic m_empty;
  logic s_full;
  logic s_empty;
  logic lim_ok;
  logic m_push_a;
  logic s_pop_a;

  // Holds all RDY outputs low until the first edge after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      en <= 1'b0;
    else
      en <= 1'b1;
  end

  assign SpMRDY_A = en & ~m_full & lim_ok;
  assign SpMVLD_B = ~m_empty;
  assign SpSRDY_B = en & ~s_full;
  assign SpSVLD_A = ~s_empty;

  assign m_push_a = SpMVLD_A & SpMRDY_A;
  assign s_pop_a  = SpSVLD_A & SpSRDY_A;

  spartan_sync_gasket_fifo #(
    .W     (W),
    .DEPTH (MDEPTH)
  ) u_mfifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (m_push_a),
    .din   (SpMBUS_A),
    .pop   (SpMVLD_B & SpMRDY_B),
    .dout  (SpMBUS_B),
    .full  (m_full),
    .empty (m_empty),
    .level (MLEVEL)
  );

  spartan_sync_gasket_fifo #(
    .W     (W),
    .DEPTH (SDEPTH)
  ) u_sfifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (SpSVLD_B & SpSRDY_B),
    .din   (SpSBUS_B),
    .pop   (s_pop_a),
    .dout  (SpSBUS_A),
    .full  (s_full),
    .empty (s_empty),
    .level (SLEVEL)
  );

  if (MAX_OUT > 0) begin : g_lim
    localparam logic [OW-1:0] MAXV = OW'(MAX_OUT);
    logic [OW-1:0] cnt;

    // Responses arriving with nothing outstanding are absorbed at zero.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)
        cnt <= '0;
      else if (m_push_a && !s_pop_a)
        cnt <= cnt + OW'(1);
      else if (s_pop_a && !m_push_a && cnt != '0)
        cnt <= cnt - OW'(1);
    end

    assign lim_ok  = (cnt < MAXV);
    assign OUTSTND = cnt;
  end else begin : g_nolim
    assign lim_ok  = 1'b1;
    assign OUTSTND = '0;
  end

endmodule
